median_loop_ctrl: RTL and testbench
===================================

# median_loop_ctrl

Iteration controller for the median filter's quickselect loop. It launches each new window into the fill-and-check stage by writing the initial control tokens: pivot, buffer size, median position and second median value. It then reads back the stage's output tokens and decides whether to run another pass or stop. It also steers the stage's pixel input between the external window stream and the feedback pixel stream, and emits one median byte per window.

## Interface
- `BUFF_SIZE`, 1024: maximum window size in pixels.
- `BUFF_SIZE_BIT`, 16: width of the size and position tokens.
- `DEFAULT_PIVOT`, 8'd127: first-pass pivot.
- `MAX_ITER`, 12: pass limit before a forced stop; must be ≥ 1.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `in_win_size`  in  BUFF_SIZE_BIT  pixel count of the next window.
- `in_win_size_empty`  in  1  window-size FIFO is empty.
- `in_win_size_rd`  out  1  window-size FIFO read.
- `out_pivot`  out  8  pivot token to the fill stage.
- `out_buff_size`  out  BUFF_SIZE_BIT  buffer-size token to the fill stage.
- `out_median_pos`  out  BUFF_SIZE_BIT  median-position token to the fill stage.
- `out_second_median_value`  out  8  second-median-value token to the fill stage.
- `out_tok_wr`  out  1  one write strobe shared by all four token FIFOs.
- `out_tok_full`  in  1  OR of the four token-FIFO full flags.
- `fb_pivot`  in  8  feedback pivot token from the fill stage.
- `fb_buff_size`  in  BUFF_SIZE_BIT  feedback buffer-size token.
- `fb_median_pos`  in  BUFF_SIZE_BIT  feedback median-position token.
- `fb_second_median_value`  in  8  feedback second-median-value token.
- `fb_tok_empty`  in  1  OR of the four feedback-FIFO empty flags.
- `fb_tok_rd`  out  1  shared read strobe for the four feedback FIFOs.
- `fb_px`  in  8  feedback pixel.
- `fb_px_empty`  in  1  feedback pixel FIFO is empty.
- `fb_px_rd`  out  1  feedback pixel read.
- `px_sel`  out  1  fill-stage pixel source: 0 = external window stream, 1 = feedback stream.
- `median`  out  8  result byte.
- `median_wr`  out  1  result write.
- `median_full`  in  1  result FIFO is full.
- `busy`  out  1  high in every state except IDLE.
- `iter_count`  out  4  passes issued for the current window.
- `err`  out  1  one-cycle pulse on a zero-size window or a MAX_ITER overrun.

## Operation
FSM states are IDLE, LOAD, ISSUE, WAIT_FB, DECIDE, TAKE_PX and EMIT.

- **IDLE.** When `in_win_size_empty`=0: assert `in_win_size_rd` and go to LOAD. The size is captured.
- **LOAD.**
  - Size = 0: pulse `err`, return to IDLE, no median.
  - Otherwise load the token registers:
    - pivot = DEFAULT_PIVOT;
    - buff_size = size;
    - median_pos = size>>1;
    - second_median_value = 0.
  - Set `px_sel`=0 and `iter_count`=0, then go to ISSUE.
- **ISSUE.**
  - `out_tok_wr` = ~`out_tok_full`; all four tokens are written in the same cycle.
  - On the write: `iter_count`++ and go to WAIT_FB.
- **WAIT_FB.**
  - When `fb_tok_empty`=0: assert `fb_tok_rd`, capture the four feedback tokens, go to DECIDE.
- **DECIDE**, in priority order:
  1. fb_buff_size = 0: result = fb_pivot, go to EMIT.
  2. fb_buff_size = 1: go to TAKE_PX.
  3. `iter_count` = MAX_ITER: pulse `err`, result = fb_pivot, go to EMIT.
  4. Otherwise: token registers ← feedback tokens, `px_sel`=1, go to ISSUE.
- **TAKE_PX.** When `fb_px_empty`=0: assert `fb_px_rd`, result = fb_px, go to EMIT.
- **EMIT.** `median_wr` = ~`median_full`. On the write go to IDLE, with `px_sel`=0.
- **Strobes.** Token, read and write strobes are combinational from state and the FIFO flags. Token and result data come from registers that are stable while their strobe can be asserted.
- **Pixel FIFOs.** The block never reads or writes the external pixel FIFO.
- **No overlap.** Windows never overlap; a new size is read only from IDLE.

## Timing
- **Reset.** State IDLE. `px_sel`, `iter_count`, `err`, `busy` and all strobes are 0. Token and result registers are 0. Reset takes effect on the next edge, from any state, and discards the current window.
- **Startup latency.** Earliest first token write is 2 cycles after `in_win_size_empty` falls.
- **Per-pass overhead.** 2 cycles of controller overhead per pass beyond the fill stage's own latency: DECIDE plus ISSUE.
- **Minimum window time.** Last feedback read to median write is at least 2 cycles (DECIDE, EMIT), or 3 cycles via TAKE_PX.
- **Backpressure.** Any full flag held high stalls the controller in place with no lost or duplicated token. `err` is a single cycle even under stall.
- **Pass counter.** `iter_count` saturates at MAX_ITER and never wraps.

## Structure
- **Shared package** (shared with the fill stage):
  - the FSM state enum;
  - the token width constant BUFF_SIZE_BIT;
  - DEFAULT_PIVOT.
- **Sub-module.** One natural sub-module: `median_token_reg`. It holds the four token registers with load-initial and load-feedback controls.
- **Top level.** The FSM lives in the top.

## Test plan
1. **Single-pass result.** Size 9 with feedback buff_size 1 and fb_px 0x42 → exactly one token write (pivot 127, buff_size 9, median_pos 4, second_median_value 0). Then one `fb_px_rd` and `median`=0x42.
2. **Multi-pass loop-back.** Feedback (pivot 60, size 5, pos 2), then (pivot 50, size 0) → second token write carries 60/5/2 with `px_sel`=1. `median`=50 and `iter_count`=2.
3. **Token backpressure.** `out_tok_full` high for 10 cycles in ISSUE → `out_tok_wr` low throughout. Exactly one write follows and token values are unchanged.
4. **Zero-size window.** `in_win_size`=0 → `err` pulses once, no token or median write, next window proceeds normally.
5. **Pass-limit overrun.** MAX_ITER=3 and feedback size 7 on every pass → 3 token writes, then `err` and `median`=last fb_pivot.
6. **Reset mid-loop.** `reset` asserted in WAIT_FB → next cycle IDLE with all outputs at reset values. A fresh window then completes correctly.

Source files
------------

// File: rtl/median_loop_ctrl_pkg.sv
// Shared definitions for the median filter quickselect loop: FSM states,
// token width and the first-pass pivot.
package median_loop_ctrl_pkg;

  localparam int         BUFF_SIZE_BIT = 16;
  localparam logic [7:0] DEFAULT_PIVOT = 8'd127;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_FB,
    DECIDE,
    TAKE_PX,
    EMIT
  } state_t;

endpackage

// File: rtl/median_token_reg.sv
// Holds the four control tokens sent to the fill stage. They are loaded either
// with first-pass values derived from the window size or from the last feedback.
module median_token_reg #(
  parameter int         BUFF_SIZE_BIT = median_loop_ctrl_pkg::BUFF_SIZE_BIT,
  parameter logic [7:0] DEFAULT_PIVOT = median_loop_ctrl_pkg::DEFAULT_PIVOT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_init,
  input  logic                     load_fb,
  input  logic [BUFF_SIZE_BIT-1:0] init_size,
  input  logic [7:0]               fb_pivot,
  input  logic [BUFF_SIZE_BIT-1:0] fb_buff_size,
  input  logic [BUFF_SIZE_BIT-1:0] fb_median_pos,
  input  logic [7:0]               fb_second_median_value,
  output logic [7:0]               pivot,
  output logic [BUFF_SIZE_BIT-1:0] buff_size,
  output logic [BUFF_SIZE_BIT-1:0] median_pos,
  output logic [7:0]               second_median_value
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pivot               <= '0;
      buff_size           <= '0;
      median_pos          <= '0;
      second_median_value <= '0;
    end else if (load_init) begin
      pivot               <= DEFAULT_PIVOT;
      buff_size           <= init_size;
      median_pos          <= init_size >> 1;
      second_median_value <= '0;
    end else if (load_fb) begin
      pivot               <= fb_pivot;
      buff_size           <= fb_buff_size;
      median_pos          <= fb_median_pos;
      second_median_value <= fb_second_median_value;
    end
  end

endmodule

// File: rtl/median_loop_ctrl.sv
// Quickselect iteration controller: launches each window into the fill stage,
// reads back its tokens, loops or stops, and emits one median byte per window.
module median_loop_ctrl #(
  parameter int         BUFF_SIZE     = 1024,
  parameter int         BUFF_SIZE_BIT = median_loop_ctrl_pkg::BUFF_SIZE_BIT,
  parameter logic [7:0] DEFAULT_PIVOT = median_loop_ctrl_pkg::DEFAULT_PIVOT,
  parameter int         MAX_ITER      = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BUFF_SIZE_BIT-1:0] in_win_size,
  input  logic                     in_win_size_empty,
  output logic                     in_win_size_rd,
  output logic [7:0]               out_pivot,
  output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
  output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
  output logic [7:0]               out_second_median_value,
  output logic                     out_tok_wr,
  input  logic                     out_tok_full,
  input  logic [7:0]               fb_pivot,
  input  logic [BUFF_SIZE_BIT-1:0] fb_buff_size,
  input  logic [BUFF_SIZE_BIT-1:0] fb_median_pos,
  input  logic [7:0]               fb_second_median_value,
  input  logic                     fb_tok_empty,
  output logic                     fb_tok_rd,
  input  logic [7:0]               fb_px,
  input  logic                     fb_px_empty,
  output logic                     fb_px_rd,
  output logic                     px_sel,
  output logic [7:0]               median,
  output logic                     median_wr,
  input  logic                     median_full,
  output logic                     busy,
  output logic [3:0]               iter_count,
  output logic                     err
);

  import median_loop_ctrl_pkg::*;

  localparam logic [3:0]               ITER_LIM = 4'(MAX_ITER);
  localparam logic [BUFF_SIZE_BIT-1:0] ONE_PX   = BUFF_SIZE_BIT'(1);

  // The pass counter is 4 bits and the window size must fit a token.
  if (MAX_ITER < 1 || MAX_ITER > 15 || BUFF_SIZE < 1 || (BUFF_SIZE >> BUFF_SIZE_BIT) != 0) begin : g_bad_cfg
    $error("median_loop_ctrl: unsupported MAX_ITER/BUFF_SIZE/BUFF_SIZE_BIT combination");
  end

  state_t                   state, state_nxt;
  logic [BUFF_SIZE_BIT-1:0] size_q;
  logic [7:0]               fb_pivot_q;
  logic [BUFF_SIZE_BIT-1:0] fb_buff_size_q;
  logic [BUFF_SIZE_BIT-1:0] fb_median_pos_q;
  logic [7:0]               fb_smv_q;
  logic [7:0]               result_q;
  logic [3:0]               iter_q;
  logic                     px_sel_q;
  logic                     load_init;
  logic                     load_fb;
  logic                     res_from_pivot;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    in_win_size_rd = 1'b0;
    out_tok_wr     = 1'b0;
    fb_tok_rd      = 1'b0;
    fb_px_rd       = 1'b0;
    median_wr      = 1'b0;
    err            = 1'b0;
    load_init      = 1'b0;
    load_fb        = 1'b0;
    res_from_pivot = 1'b0;
    case (state)
      IDLE: begin
        if (!in_win_size_empty) begin
          in_win_size_rd = 1'b1;
          state_nxt      = LOAD;
        end
      end
      LOAD: begin
        if (size_q == '0) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else begin
          load_init = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        out_tok_wr = !out_tok_full;
        if (!out_tok_full) state_nxt = WAIT_FB;
      end
      WAIT_FB: begin
        fb_tok_rd = !fb_tok_empty;
        if (!fb_tok_empty) state_nxt = DECIDE;
      end
      DECIDE: begin
        if (fb_buff_size_q == '0) begin
          res_from_pivot = 1'b1;
          state_nxt      = EMIT;
        end else if (fb_buff_size_q == ONE_PX) begin
          state_nxt = TAKE_PX;
        end else if (iter_q == ITER_LIM) begin
          err            = 1'b1;
          res_from_pivot = 1'b1;
          state_nxt      = EMIT;
        end else begin
          load_fb   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      TAKE_PX: begin
        fb_px_rd = !fb_px_empty;
        if (!fb_px_empty) state_nxt = EMIT;
      end
      EMIT: begin
        median_wr = !median_full;
        if (!median_full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      size_q          <= '0;
      fb_pivot_q      <= '0;
      fb_buff_size_q  <= '0;
      fb_median_pos_q <= '0;
      fb_smv_q        <= '0;
      result_q        <= '0;
      iter_q          <= '0;
      px_sel_q        <= 1'b0;
    end else begin
      if (in_win_size_rd) size_q <= in_win_size;
      if (load_init) begin
        iter_q   <= '0;
        px_sel_q <= 1'b0;
      end
      if (out_tok_wr && iter_q != ITER_LIM) iter_q <= iter_q + 4'd1;
      if (fb_tok_rd) begin
        fb_pivot_q      <= fb_pivot;
        fb_buff_size_q  <= fb_buff_size;
        fb_median_pos_q <= fb_median_pos;
        fb_smv_q        <= fb_second_median_value;
      end
      if (load_fb)        px_sel_q <= 1'b1;
      if (res_from_pivot) result_q <= fb_pivot_q;
      if (fb_px_rd)       result_q <= fb_px;
      if (median_wr)      px_sel_q <= 1'b0;
    end
  end

  median_token_reg #(
    .BUFF_SIZE_BIT (BUFF_SIZE_BIT),
    .DEFAULT_PIVOT (DEFAULT_PIVOT)
  ) u_token_reg (
    .clock                  (clock),
    .reset                  (reset),
    .load_init              (load_init),
    .load_fb                (load_fb),
    .init_size              (size_q),
    .fb_pivot               (fb_pivot_q),
    .fb_buff_size           (fb_buff_size_q),
    .fb_median_pos          (fb_median_pos_q),
    .fb_second_median_value (fb_smv_q),
    .pivot                  (out_pivot),
    .buff_size              (out_buff_size),
    .median_pos             (out_median_pos),
    .second_median_value    (out_second_median_value)
  );

  assign px_sel     = px_sel_q;
  assign median     = result_q;
  assign busy       = (state != IDLE);
  assign iter_count = iter_q;

endmodule

// File: tb/tb_median_loop_ctrl.sv
// Bench for median_loop_ctrl: emulates the FIFOs and fill stage, predicts token
// writes, medians and errors per window, and checks every strobe cycle.
module tb_median_loop_ctrl;

  localparam int BW   = 16;
  localparam int MAXI = 3;

  typedef struct packed {
    logic [7:0]    pivot;
    logic [BW-1:0] bs;
    logic [BW-1:0] pos;
    logic [7:0]    smv;
  } tok_t;
  typedef struct packed { tok_t t; logic sel; logic [3:0] iter; } exp_tok_t;
  typedef struct packed { logic [7:0] val; logic [3:0] iter; } exp_med_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [BW-1:0] in_win_size;
  logic          in_win_size_empty, in_win_size_rd;
  logic [7:0]    out_pivot, out_second_median_value;
  logic [BW-1:0] out_buff_size, out_median_pos;
  logic          out_tok_wr, out_tok_full;
  logic [7:0]    fb_pivot, fb_second_median_value;
  logic [BW-1:0] fb_buff_size, fb_median_pos;
  logic          fb_tok_empty, fb_tok_rd;
  logic [7:0]    fb_px;
  logic          fb_px_empty, fb_px_rd;
  logic          px_sel;
  logic [7:0]    median;
  logic          median_wr, median_full, busy, err;
  logic [3:0]    iter_count;

  always #5 clock = ~clock;

  median_loop_ctrl #(
    .BUFF_SIZE     (1024),
    .BUFF_SIZE_BIT (BW),
    .DEFAULT_PIVOT (8'd127),
    .MAX_ITER      (MAXI)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_win_size             (in_win_size),
    .in_win_size_empty       (in_win_size_empty),
    .in_win_size_rd          (in_win_size_rd),
    .out_pivot               (out_pivot),
    .out_buff_size           (out_buff_size),
    .out_median_pos          (out_median_pos),
    .out_second_median_value (out_second_median_value),
    .out_tok_wr              (out_tok_wr),
    .out_tok_full            (out_tok_full),
    .fb_pivot                (fb_pivot),
    .fb_buff_size            (fb_buff_size),
    .fb_median_pos           (fb_median_pos),
    .fb_second_median_value  (fb_second_median_value),
    .fb_tok_empty            (fb_tok_empty),
    .fb_tok_rd               (fb_tok_rd),
    .fb_px                   (fb_px),
    .fb_px_empty             (fb_px_empty),
    .fb_px_rd                (fb_px_rd),
    .px_sel                  (px_sel),
    .median                  (median),
    .median_wr               (median_wr),
    .median_full             (median_full),
    .busy                    (busy),
    .iter_count              (iter_count),
    .err                     (err)
  );

  logic [BW-1:0] size_q[$];
  logic [7:0]    px_q[$];
  tok_t          fb_script[$], fb_avail[$], stage[$];
  exp_tok_t      exp_tok[$];
  exp_med_t      exp_med[$];

  int checks = 0, errors = 0, exp_err = 0;
  int n_err = 0, n_tok = 0, n_med = 0, n_pxrd = 0;
  logic [7:0] last_med;
  logic [3:0] last_iter;
  tok_t       last_tok;
  logic       last_sel;
  logic       prev_err = 1'b0;
  logic       tok_full_ctl = 1'b0, med_full_ctl = 1'b0, fb_hold = 1'b0;
  logic       s_size_rd = 1'b0, s_tok_wr = 1'b0, s_fb_rd = 1'b0, s_px_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    in_win_size_empty = (size_q.size() == 0);
    in_win_size       = (size_q.size() != 0) ? size_q[0] : '0;
    out_tok_full      = tok_full_ctl;
    fb_tok_empty      = fb_hold || (fb_avail.size() == 0);
    if (fb_avail.size() != 0) begin
      fb_pivot               = fb_avail[0].pivot;
      fb_buff_size           = fb_avail[0].bs;
      fb_median_pos          = fb_avail[0].pos;
      fb_second_median_value = fb_avail[0].smv;
    end else begin
      fb_pivot = '0; fb_buff_size = '0; fb_median_pos = '0; fb_second_median_value = '0;
    end
    fb_px_empty = (px_q.size() == 0);
    fb_px       = (px_q.size() != 0) ? px_q[0] : '0;
    median_full = med_full_ctl;
  endtask

  task automatic add_fb(input logic [7:0] p, input logic [BW-1:0] bs, input logic [BW-1:0] pos,
                        input logic [7:0] smv);
    tok_t t;
    t.pivot = p; t.bs = bs; t.pos = pos; t.smv = smv;
    stage.push_back(t);
  endtask

  // Reference model: from the window size and scripted feedback, work out every
  // token write, the median and any error the controller must produce.
  task automatic launch(input logic [BW-1:0] size, input logic [7:0] px);
    tok_t     cur;
    logic     sel;
    exp_tok_t et;
    exp_med_t em;
    size_q.push_back(size);
    if (size == 0) begin
      exp_err++;
      stage.delete();
      return;
    end
    cur.pivot = 8'd127; cur.bs = size; cur.pos = size / 2; cur.smv = 8'd0;
    sel = 1'b0;
    for (int i = 0; i < stage.size(); i++) begin
      et.t = cur; et.sel = sel; et.iter = 4'(i);
      exp_tok.push_back(et);
      fb_script.push_back(stage[i]);
      em.iter = 4'(i + 1);
      if (stage[i].bs == 0) begin
        em.val = stage[i].pivot; exp_med.push_back(em); break;
      end
      if (stage[i].bs == 1) begin
        px_q.push_back(px); em.val = px; exp_med.push_back(em); break;
      end
      if (i + 1 == MAXI) begin
        exp_err++; em.val = stage[i].pivot; exp_med.push_back(em); break;
      end
      cur = stage[i];
      sel = 1'b1;
    end
    stage.delete();
  endtask

  // Compare process: strobes are sampled on the falling edge and take effect
  // on the following rising edge.
  always @(negedge clock) begin
    exp_tok_t et;
    exp_med_t em;
    if (reset) begin
      s_size_rd = 1'b0; s_tok_wr = 1'b0; s_fb_rd = 1'b0; s_px_rd = 1'b0;
    end else begin
      s_size_rd = in_win_size_rd; s_tok_wr = out_tok_wr; s_fb_rd = fb_tok_rd; s_px_rd = fb_px_rd;
      if (out_tok_wr) begin
        n_tok++;
        last_tok.pivot = out_pivot; last_tok.bs = out_buff_size;
        last_tok.pos = out_median_pos; last_tok.smv = out_second_median_value;
        last_sel = px_sel;
        check("tok_wr_while_full", 32'(out_tok_full), 0);
        check("tok_wr_expected", 32'(exp_tok.size() != 0), 1);
        if (exp_tok.size() != 0) begin
          et = exp_tok.pop_front();
          check("tok_pivot", 32'(out_pivot), 32'(et.t.pivot));
          check("tok_buff_size", 32'(out_buff_size), 32'(et.t.bs));
          check("tok_median_pos", 32'(out_median_pos), 32'(et.t.pos));
          check("tok_smv", 32'(out_second_median_value), 32'(et.t.smv));
          check("tok_px_sel", 32'(px_sel), 32'(et.sel));
          check("tok_iter_count", 32'(iter_count), 32'(et.iter));
        end
      end
      if (median_wr) begin
        n_med++;
        last_med  = median;
        last_iter = iter_count;
        check("median_wr_while_full", 32'(median_full), 0);
        check("median_expected", 32'(exp_med.size() != 0), 1);
        if (exp_med.size() != 0) begin
          em = exp_med.pop_front();
          check("median_value", 32'(median), 32'(em.val));
          check("median_iter_count", 32'(iter_count), 32'(em.iter));
        end
      end
      if (fb_px_rd) n_pxrd++;
      if (err) begin
        n_err++;
        check("err_single_cycle", 32'(prev_err), 0);
      end
    end
    prev_err = err;
  end

  always @(posedge clock) begin
    #1;
    if (s_size_rd && size_q.size() != 0) void'(size_q.pop_front());
    if (s_tok_wr && fb_script.size() != 0) fb_avail.push_back(fb_script.pop_front());
    if (s_fb_rd && fb_avail.size() != 0) void'(fb_avail.pop_front());
    if (s_px_rd && px_q.size() != 0) void'(px_q.pop_front());
    drive_inputs();
  end

  task automatic wait_done(input string name, input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clock); #1;
      done = !busy && size_q.size() == 0 && exp_tok.size() == 0 && exp_med.size() == 0;
    end
    check(name, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, m0, e0, p0;
    reset = 1'b1;
    drive_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_px_sel", 32'(px_sel), 0);
    check("rst_iter", 32'(iter_count), 0);
    check("rst_err", 32'(err), 0);
    check("rst_tok_wr", 32'(out_tok_wr), 0);
    check("rst_fb_rd", 32'(fb_tok_rd), 0);
    check("rst_median_wr", 32'(median_wr), 0);
    check("rst_pivot", 32'(out_pivot), 0);
    check("rst_buff_size", 32'(out_buff_size), 0);
    check("rst_median", 32'(median), 0);
    reset = 1'b0;

    // single pass finishing through the feedback pixel
    t0 = n_tok; m0 = n_med; p0 = n_pxrd;
    add_fb(8'd100, 16'd1, 16'd0, 8'd0);
    launch(16'd9, 8'h42);
    wait_done("t1_done", 100);
    check("t1_tok_count", 32'(n_tok - t0), 1);
    check("t1_tok_pivot", 32'(last_tok.pivot), 127);
    check("t1_tok_size", 32'(last_tok.bs), 9);
    check("t1_tok_pos", 32'(last_tok.pos), 4);
    check("t1_tok_smv", 32'(last_tok.smv), 0);
    check("t1_px_rd_count", 32'(n_pxrd - p0), 1);
    check("t1_median", 32'(last_med), 32'h42);
    check("t1_med_count", 32'(n_med - m0), 1);

    // two passes with loop-back
    t0 = n_tok;
    add_fb(8'd60, 16'd5, 16'd2, 8'd9);
    add_fb(8'd50, 16'd0, 16'd0, 8'd0);
    launch(16'd11, 8'h00);
    wait_done("t2_done", 100);
    check("t2_tok_count", 32'(n_tok - t0), 2);
    check("t2_tok_pivot", 32'(last_tok.pivot), 60);
    check("t2_tok_size", 32'(last_tok.bs), 5);
    check("t2_tok_pos", 32'(last_tok.pos), 2);
    check("t2_px_sel", 32'(last_sel), 1);
    check("t2_median", 32'(last_med), 50);
    check("t2_iter", 32'(last_iter), 2);

    // token backpressure
    t0 = n_tok;
    tok_full_ctl = 1'b1;
    add_fb(8'd77, 16'd0, 16'd0, 8'd0);
    launch(16'd6, 8'h00);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      check("t3_stall_tok_wr", 32'(out_tok_wr), 0);
      check("t3_stall_size", 32'(out_buff_size), 6);
    end
    check("t3_stall_count", 32'(n_tok - t0), 0);
    tok_full_ctl = 1'b0;
    wait_done("t3_done", 100);
    check("t3_tok_count", 32'(n_tok - t0), 1);
    check("t3_tok_pos", 32'(last_tok.pos), 3);
    check("t3_median", 32'(last_med), 77);

    // zero-size window followed by a normal one
    t0 = n_tok; m0 = n_med; e0 = n_err;
    launch(16'd0, 8'h00);
    add_fb(8'd33, 16'd0, 16'd0, 8'd0);
    launch(16'd7, 8'h00);
    wait_done("t4_done", 100);
    check("t4_err_count", 32'(n_err - e0), 1);
    check("t4_tok_count", 32'(n_tok - t0), 1);
    check("t4_med_count", 32'(n_med - m0), 1);
    check("t4_median", 32'(last_med), 33);

    // pass-limit overrun with the result FIFO stalled
    t0 = n_tok; m0 = n_med; e0 = n_err;
    med_full_ctl = 1'b1;
    add_fb(8'd30, 16'd7, 16'd3, 8'd1);
    add_fb(8'd31, 16'd7, 16'd3, 8'd2);
    add_fb(8'd32, 16'd7, 16'd3, 8'd3);
    launch(16'd20, 8'h00);
    repeat (30) @(negedge clock);
    #1;
    check("t5_med_stalled", 32'(n_med - m0), 0);
    med_full_ctl = 1'b0;
    wait_done("t5_done", 100);
    check("t5_tok_count", 32'(n_tok - t0), 3);
    check("t5_err_count", 32'(n_err - e0), 1);
    check("t5_median", 32'(last_med), 32);
    check("t5_iter", 32'(last_iter), 3);

    // reset while waiting for feedback
    t0 = n_tok;
    fb_hold = 1'b1;
    add_fb(8'd90, 16'd0, 16'd0, 8'd0);
    launch(16'd9, 8'h00);
    for (int i = 0; i < 50 && n_tok == t0; i++) @(negedge clock);
    check("t6_first_write", 32'(n_tok - t0), 1);
    repeat (2) @(negedge clock);
    #1;
    check("t6_busy_before", 32'(busy), 1);
    reset = 1'b1;
    fb_script.delete(); fb_avail.delete(); px_q.delete(); size_q.delete();
    exp_tok.delete(); exp_med.delete();
    fb_hold = 1'b0;
    @(negedge clock); #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_px_sel", 32'(px_sel), 0);
    check("t6_rst_iter", 32'(iter_count), 0);
    check("t6_rst_pivot", 32'(out_pivot), 0);
    check("t6_rst_size", 32'(out_buff_size), 0);
    check("t6_rst_pos", 32'(out_median_pos), 0);
    check("t6_rst_median", 32'(median), 0);
    check("t6_rst_fb_rd", 32'(fb_tok_rd), 0);
    reset = 1'b0;
    add_fb(8'd61, 16'd5, 16'd2, 8'd0);
    add_fb(8'd44, 16'd1, 16'd0, 8'd0);
    launch(16'd13, 8'h99);
    wait_done("t6_done", 100);
    check("t6_median", 32'(last_med), 32'h99);
    check("t6_iter", 32'(last_iter), 2);

    repeat (3) @(negedge clock);
    check("err_count_total", 32'(n_err), 32'(exp_err));
    check("exp_queues_drained", 32'(exp_tok.size() + exp_med.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
